// File: rtl/ex_stage.sv
// RV32I execute stage: forwarding, ALU, branch resolution, EX/MEM register.
// Define EX_FORWARD_EN to enable operand forwarding from MEM and WB.
module ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWriteE,
    input  logic        MemReadE,
    input  logic        MemWriteE,
    input  logic [2:0]  WriteBackE,
    input  logic [2:0]  funct3E,
    input  logic [3:0]  ALUControlE,
    input  logic        ALUSrcAE,
    input  logic        ALUSrcBE,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic        JalrE,
    input  logic [31:0] RD1E,
    input  logic [31:0] RD2E,
    input  logic [31:0] PCE,
    input  logic [31:0] ImmExtE,
    input  logic [31:0] PCPlus4E,
    input  logic [4:0]  RdE,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] ResultW,
    input  logic        StallM,
    input  logic        FlushM,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemReadM,
    output logic        MemWriteM,
    output logic [2:0]  WriteBackM,
    output logic [2:0]  funct3M,
    output logic [31:0] ALUResultM,
    output logic [31:0] WriteDataM,
    output logic [31:0] PCTargetM,
    output logic [31:0] PCPlus4M,
    output logic [31:0] ImmExtM,
    output logic [4:0]  RdM
);

    logic        reg_write_q, mem_read_q, mem_write_q;
    logic [2:0]  wb_q, funct3_q;
    logic [31:0] alu_q, wdata_q, target_q, pc4_q, imm_q;
    logic [4:0]  rd_q;

    logic [31:0] fwd_a, fwd_b, src_a, src_b;
    logic [31:0] alu_d, tgt_sum;
    logic [4:0]  shamt;
    logic        eq, lt_s, lt_u, br_taken;

`ifdef EX_FORWARD_EN
    always_comb begin
        case (ForwardAE)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = alu_q;
            default: fwd_a = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = alu_q;
            default: fwd_b = RD2E;
        endcase
    end
`else
    // Forwarding disabled: the hazard unit stalls, selects are don't-care.
    logic unused_fwd;
    assign unused_fwd = ^{ForwardAE, ForwardBE, ResultW};
    assign fwd_a = RD1E;
    assign fwd_b = RD2E;
`endif

    assign src_a = ALUSrcAE ? PCE : fwd_a;
    assign src_b = ALUSrcBE ? ImmExtE : fwd_b;
    assign shamt = src_b[4:0];

    always_comb begin
        alu_d = '0;
        case (ALUControlE)
            4'b0000: alu_d = src_a + src_b;
            4'b0001: alu_d = src_a - src_b;
            4'b0010: alu_d = src_a & src_b;
            4'b0011: alu_d = src_a | src_b;
            4'b0100: alu_d = src_a ^ src_b;
            4'b0101: alu_d = {31'b0, $signed(src_a) < $signed(src_b)};
            4'b0110: alu_d = {31'b0, src_a < src_b};
            4'b0111: alu_d = src_a << shamt;
            4'b1000: alu_d = src_a >> shamt;
            4'b1001: alu_d = $unsigned($signed(src_a) >>> shamt);
            4'b1010: alu_d = src_b;
            default: alu_d = '0;
        endcase
    end

    assign eq   = (fwd_a == fwd_b);
    assign lt_s = ($signed(fwd_a) < $signed(fwd_b));
    assign lt_u = (fwd_a < fwd_b);

    always_comb begin
        br_taken = 1'b0;
        case (funct3E)
            3'b000:  br_taken = eq;
            3'b001:  br_taken = ~eq;
            3'b100:  br_taken = lt_s;
            3'b101:  br_taken = ~lt_s;
            3'b110:  br_taken = lt_u;
            3'b111:  br_taken = ~lt_u;
            default: br_taken = 1'b0;
        endcase
    end

    assign tgt_sum   = (JalrE ? fwd_a : PCE) + ImmExtE;
    assign PCTargetE = {tgt_sum[31:1], tgt_sum[0] & ~JalrE};
    assign PCSrcE    = JumpE | (BranchE & br_taken);

    // Flush outranks stall so a squashed instruction never lingers in MEM.
    always_ff @(posedge clk) begin
        if (reset || FlushM) begin
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            wb_q        <= '0;
            funct3_q    <= '0;
            alu_q       <= '0;
            wdata_q     <= '0;
            target_q    <= '0;
            pc4_q       <= '0;
            imm_q       <= '0;
            rd_q        <= '0;
        end else if (!StallM) begin
            reg_write_q <= RegWriteE;
            mem_read_q  <= MemReadE;
            mem_write_q <= MemWriteE;
            wb_q        <= WriteBackE;
            funct3_q    <= funct3E;
            alu_q       <= alu_d;
            wdata_q     <= fwd_b;
            target_q    <= PCTargetE;
            pc4_q       <= PCPlus4E;
            imm_q       <= ImmExtE;
            rd_q        <= RdE;
        end
    end

    assign RegWriteM  = reg_write_q;
    assign MemReadM   = mem_read_q;
    assign MemWriteM  = mem_write_q;
    assign WriteBackM = wb_q;
    assign funct3M    = funct3_q;
    assign ALUResultM = alu_q;
    assign WriteDataM = wdata_q;
    assign PCTargetM  = target_q;
    assign PCPlus4M   = pc4_q;
    assign ImmExtM    = imm_q;
    assign RdM        = rd_q;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the RV32I five-stage pipeline. Operand forwarding, ALU, branch/jump resolution and the EX/MEM pipeline register live here. Its registered outputs feed the memory stage directly. It also returns the branch redirect (PCSrcE, PCTargetE) combinationally to fetch.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock; the only clock
- reset  in  1  synchronous, active-high; clears the EX/MEM register
- RegWriteE, MemReadE, MemWriteE  in  1 each  control bits from ID/EX
- WriteBackE  in  3  write-back select, passed through
- funct3E  in  3  branch condition, and memory access size passed to MEM
- ALUControlE  in  4  ALU opcode (see Operation)
- ALUSrcAE  in  1  0: forwarded rs1, 1: PCE
- ALUSrcBE  in  1  0: forwarded rs2, 1: ImmExtE
- BranchE, JumpE, JalrE  in  1 each  control-flow type
- RD1E, RD2E, PCE, ImmExtE, PCPlus4E  in  32 each  operands from ID/EX
- RdE  in  5  destination register
- ForwardAE, ForwardBE  in  2 each  forwarding selects from the hazard unit
- ResultW  in  32  write-back result, used for forwarding
- StallM  in  1  hold the EX/MEM register
- FlushM  in  1  load a bubble into EX/MEM
- PCSrcE  out  1  redirect fetch (combinational)
- PCTargetE  out  32  redirect address (combinational)
- RegWriteM, MemReadM, MemWriteM  out  1 each  registered
- WriteBackM, funct3M  out  3 each  registered
- ALUResultM, WriteDataM, PCTargetM, PCPlus4M, ImmExtM  out  32 each  registered
- RdM  out  5  registered

## Operation
- Forwarding, applied independently to rs1 and rs2:
  - 00: the RD value.
  - 01: ResultW.
  - 10: ALUResultM, the own register output.
  - 11: same as 00.
- Naming:
  - FwdA is the forwarded rs1 value; FwdB is the forwarded rs2 value.
  - SrcA = ALUSrcAE ? PCE : FwdA.
  - SrcB = ALUSrcBE ? ImmExtE : FwdB.
- ALUControlE encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed), 0110 SLTU.
  - 0111 SLL, 1000 SRL, 1001 SRA; shift amount is SrcB[4:0].
  - 1010 PASSB (used for LUI).
  - 1011–1111 produce 0.
- Arithmetic is 32-bit modulo 2^32. SLT and SLTU produce 0 or 1 in bit 0.
- Branch condition from funct3E, comparing FwdA against FwdB:
  - 000 BEQ, 001 BNE.
  - 100 BLT, 101 BGE (signed).
  - 110 BLTU, 111 BGEU (unsigned).
  - 010 and 011 are never taken.
- PCTargetE = (JalrE ? FwdA : PCE) + ImmExtE. When JalrE = 1, bit 0 is forced to 0.
- PCSrcE = JumpE | (BranchE & condition). JALR requires JumpE = 1.
- WriteDataM captures FwdB, so stores see forwarded data.
- EX/MEM register, per clock edge, in priority order:
  1. reset: all outputs cleared.
  2. FlushM: all outputs cleared (bubble).
  3. StallM: outputs hold.
  4. Otherwise: load the E-side values and the computed ALU result and PCTargetE.

## Timing
- Reset value of every registered output is 0. A bubble therefore has RegWriteM = MemReadM = MemWriteM = 0.
- Forwarding, ALU, compare, PCSrcE and PCTargetE are combinational, with no internal state. ALU result latency to ALUResultM is 1 cycle.
- FlushM and StallM asserted in the same cycle: flush wins.
- reset asserted mid-operation: the bubble appears on the next edge regardless of StallM or FlushM.
- While StallM = 1, ALUResultM is stable, so forwarding select 10 returns the held value.
- PCSrcE is not gated by StallM or FlushM. Suppressing a redirect from a dead instruction is the hazard unit's responsibility.

## Configuration
- Macro: EX_FORWARD_EN.
- Defined: forwarding as described above.
- Undefined:
  - ForwardAE and ForwardBE are ignored; FwdA = RD1E and FwdB = RD2E.
  - Ports remain present.
  - The hazard unit must stall instead of forwarding.

## Test plan
- ADD, RD1E=0x7FFFFFFF, RD2E=1, ALUSrcBE=0, one clock → ALUResultM=0x80000000, RdM equals RdE, RegWriteM=1.
- SRA, RD1E=0x80000000, ImmExtE=4, ALUSrcBE=1 → ALUResultM=0xF8000000. SLTU with RD1E=0xFFFFFFFF, RD2E=1 → 0.
- Forwarding:
  - Cycle 1: ADD producing 5. Cycle 2: ForwardAE=10, RD1E=0, ImmExtE=3, ALUSrcBE=1 → ALUResultM=8.
  - ForwardBE=01 with ResultW=0xAA and MemWriteE=1 → WriteDataM=0xAA.
  - Without EX_FORWARD_EN, the same stimulus gives operand 0.
- BLT, FwdA=0xFFFFFFFF, FwdB=1, BranchE=1, PCE=0x100, ImmExtE=0x20 → PCSrcE=1, PCTargetE=0x120. BLTU with the same operands → PCSrcE=0.
- JALR, FwdA=0x203, ImmExtE=0, JumpE=1, JalrE=1 → PCTargetE=0x202, PCSrcE=1, PCPlus4M captured.
- Control priority:
  - Load a valid instruction, then hold StallM=1 for 2 cycles with changing inputs → outputs unchanged.
  - StallM=1 together with FlushM=1 → all outputs 0.
  - reset asserted with StallM=1 → all outputs 0.
